uniq_extract: RTL and testbench

UNIQ_EXTRACT -- requirements
Module: uniq_extract

---
 rtl/uniq_extract_if.sv | 29 ++
 rtl/uniq_extract.sv | 203 ++++++++++++++++++++
 tb/tb_uniq_extract.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uniq_extract_if.sv
// Bundle for uniq_extract: A write port, start/len request, status and B read port.
// The DUT takes the slave modport and the driver takes the master modport.
interface uniq_extract_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [CW-1:0]    len;
  logic             start;
  logic             busy;
  logic             done;
  logic [CW-1:0]    count;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, len, start, rd_addr,
    input  busy, done, count, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, start, rd_addr,
    output busy, done, count, rd_data
  );
endinterface

// File: rtl/uniq_extract.sv
// Extracts the unique elements of A[0..L-1] into B and reports how many were found.
// Optional UNIQ_SORT_EN: selection-sorts A in place first, so B comes out ascending.
module uniq_extract #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst,
  uniq_extract_if.slave bus
);
  // One extra bit lets an index reach DEPTH without wrapping.
  localparam int NW = CW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef UNIQ_SORT_EN
    SORT = 2'd1,
`endif
    SCAN = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q [DEPTH];
  logic [WIDTH-1:0] a_d [DEPTH];
  logic [WIDTH-1:0] b_q [DEPTH];
  logic [WIDTH-1:0] b_d [DEPTH];
  logic [CW-1:0]    l_q, l_d;
  logic [NW-1:0]    m_q, m_d;
  logic [NW-1:0]    j_q, j_d;
  logic [NW-1:0]    k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NW-1:0]    l_ext;
  logic [NW-1:0]    m_next;
  logic [WIDTH-1:0] a_m;
`ifdef UNIQ_SORT_EN
  logic [NW-1:0]    i_q, i_d;
  logic [NW-1:0]    mi_q, mi_d;
  logic [NW-1:0]    k_dec;
`endif

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.count   = count_q;
  assign bus.rd_data = rd_data_q;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    l_d       = l_q;
    m_d       = m_q;
    j_d       = j_q;
    k_d       = k_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    count_d   = count_q;
    rd_data_d = b_q[bus.rd_addr];
    l_ext     = {1'b0, l_q};
    m_next    = m_q + NW'(1);
    a_m       = a_q[m_q[AW-1:0]];
`ifdef UNIQ_SORT_EN
    i_d       = i_q;
    mi_d      = mi_q;
    k_dec     = k_q - NW'(1);
`endif
    case (state_q)
      IDLE: begin
        // The write lands on the same edge that accepts start, so the run sees it.
        if (bus.wr_en) begin
          a_d[bus.wr_addr] = bus.wr_data;
        end else begin
          a_d = a_q;
        end
        if (bus.start) begin
          l_d     = (bus.len > CW'(DEPTH)) ? CW'(DEPTH) : bus.len;
          m_d     = '0;
          j_d     = '0;
          k_d     = '0;
          count_d = '0;
          busy_d  = 1'b1;
`ifdef UNIQ_SORT_EN
          i_d     = '0;
          mi_d    = '0;
          j_d     = NW'(1);
          state_d = (bus.len == CW'(0)) ? FIN : SORT;
`else
          state_d = (bus.len == CW'(0)) ? FIN : SCAN;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef UNIQ_SORT_EN
      SORT: begin
        if (i_q + NW'(1) >= l_ext) begin
          state_d = SCAN;
          m_d     = '0;
          j_d     = '0;
        end else if (j_q < l_ext) begin
          if (a_q[j_q[AW-1:0]] < a_q[mi_q[AW-1:0]]) begin
            mi_d = j_q;
          end else begin
            mi_d = mi_q;
          end
          j_d = j_q + NW'(1);
        end else begin
          // End of pass: one cycle to swap the minimum into position i.
          a_d[i_q[AW-1:0]]  = a_q[mi_q[AW-1:0]];
          a_d[mi_q[AW-1:0]] = a_q[i_q[AW-1:0]];
          i_d  = i_q + NW'(1);
          mi_d = i_q + NW'(1);
          j_d  = i_q + NW'(2);
        end
      end
      SCAN: begin
        // Sorted input: duplicates are adjacent, so only the last entry of B matters.
        if ((k_q == NW'(0)) || (a_m != b_q[k_dec[AW-1:0]])) begin
          b_d[k_q[AW-1:0]] = a_m;
          k_d = k_q + NW'(1);
        end else begin
          k_d = k_q;
        end
        m_d     = m_next;
        state_d = (m_next >= l_ext) ? FIN : SCAN;
      end
`else
      SCAN: begin
        if (j_q < k_q) begin
          if (a_m == b_q[j_q[AW-1:0]]) begin
            m_d     = m_next;
            j_d     = '0;
            state_d = (m_next >= l_ext) ? FIN : SCAN;
          end else begin
            j_d = j_q + NW'(1);
          end
        end else begin
          b_d[k_q[AW-1:0]] = a_m;
          k_d     = k_q + NW'(1);
          m_d     = m_next;
          j_d     = '0;
          state_d = (m_next >= l_ext) ? FIN : SCAN;
        end
      end
`endif
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        count_d = k_q[CW-1:0];
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      l_q       <= '0;
      m_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      rd_data_q <= '0;
`ifdef UNIQ_SORT_EN
      i_q       <= '0;
      mi_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      m_q       <= m_d;
      j_q       <= j_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
`ifdef UNIQ_SORT_EN
      i_q       <= i_d;
      mi_q      <= mi_d;
`endif
    end
  end

  // Storage arrays carry no reset so their contents survive rst.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end
endmodule

// File: tb/tb_uniq_extract.sv
// Directed self-checking bench for uniq_extract; expected results follow UNIQ_SORT_EN.
module tb_uniq_extract;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  uniq_extract_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  uniq_extract #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
    bus.rd_addr = 4'(addr);
    step();
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic wait_done(input int first, output int cyc);
    cyc = first;
    while (bus.done !== 1'b1 && cyc < 400) begin
      step();
      cyc++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  // cyc counts rising edges from the start-accepting edge (=1) to the edge raising done.
  task automatic run(input int l, output int cyc);
    bus.len   = 5'(l);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    wait_done(1, cyc);
  endtask

  task automatic load9();
    int v9 [9] = '{9, 8, 1, 8, 1, 8, 1, 8, 1};
    for (int i = 0; i < 9; i++) wr(i, 32'(v9[i]));
  endtask

  initial begin
    int          cyc;
    logic        seen;
    logic [31:0] e0, e1, e2;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.len     = '0;
    bus.start   = 1'b0;
    bus.rd_addr = '0;
    @(negedge clk);
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    rst = 1'b0;
    step();

    // Mixed duplicates, len=9.
    load9();
    run(9, cyc);
    chk("t1_count", 32'(bus.count), 32'd3);
    chk("t1_bound", 32'(cyc <= 92), 32'd1);
    step();
    chk("t1_done_pulse", 32'(bus.done), 32'd0);
`ifdef UNIQ_SORT_EN
    e0 = 32'd1; e1 = 32'd8; e2 = 32'd9;
    for (int i = 0; i < 9; i++)
      chk("t1_a_sorted", dut.a_q[i], (i < 4) ? 32'd1 : ((i < 8) ? 32'd8 : 32'd9));
`else
    e0 = 32'd9; e1 = 32'd8; e2 = 32'd1;
`endif
    rd_chk("t1_b0", 0, e0);
    rd_chk("t1_b1", 1, e1);
    rd_chk("t1_b2", 2, e2);

    // All equal, len=DEPTH; entries past count keep their old value.
    for (int i = 0; i < DEPTH; i++) wr(i, 32'hDEADBEEF);
    run(DEPTH, cyc);
    chk("t2_count", 32'(bus.count), 32'd1);
    rd_chk("t2_b0", 0, 32'hDEADBEEF);
    rd_chk("t2_b1_kept", 1, 32'd8);

    // All distinct, descending, len=DEPTH.
    for (int i = 0; i < DEPTH; i++) wr(i, 32'(DEPTH - 1 - i));
    run(DEPTH, cyc);
    chk("t3_count", 32'(bus.count), 32'd16);
    chk("t3_bound", 32'(cyc <= 274), 32'd1);
`ifdef UNIQ_SORT_EN
    e0 = 32'd0; e1 = 32'd15;
`else
    e0 = 32'd15; e1 = 32'd0;
`endif
    rd_chk("t3_b0", 0, e0);
    rd_chk("t3_b15", 15, e1);

    // len above DEPTH is clamped to DEPTH.
    run(DEPTH + 5, cyc);
    chk("t4_count", 32'(bus.count), 32'd16);
    chk("t4_bound", 32'(cyc <= 274), 32'd1);
    rd_chk("t4_b15", 15, e1);

    // len=0: done two edges after the start edge.
    run(0, cyc);
    chk("t5_cycles", 32'(cyc), 32'd2);
    chk("t5_count", 32'(bus.count), 32'd0);

    // Reset three cycles into a run aborts it silently; a rerun is correct.
    load9();
    bus.len   = 5'd9;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_done", 32'(bus.done), 32'd0);
    chk("t6_count", 32'(bus.count), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("t6_no_done", 32'(seen), 32'd0);
    run(9, cyc);
    chk("t6_rerun_count", 32'(bus.count), 32'd3);
`ifdef UNIQ_SORT_EN
    e0 = 32'd1; e2 = 32'd9;
`else
    e0 = 32'd9; e2 = 32'd1;
`endif
    rd_chk("t6_b0", 0, e0);
    rd_chk("t6_b2", 2, e2);

    // Start and write while busy are ignored.
    wr(0, 32'd5);
    wr(1, 32'd5);
    wr(2, 32'd6);
    bus.len   = 5'd3;
    bus.start = 1'b1;
    step();
    chk("t7_busy", 32'(bus.busy), 32'd1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd0;
    bus.wr_data = 32'd99;
    bus.len     = 5'd1;
    step();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    wait_done(2, cyc);
    chk("t7_count", 32'(bus.count), 32'd2);
    rd_chk("t7_b0", 0, 32'd5);
    rd_chk("t7_b1", 1, 32'd6);
    run(1, cyc);
    chk("t7_a0_kept", 32'(bus.count), 32'd1);
    rd_chk("t7_a0_val", 0, 32'd5);

    // Write coinciding with an accepted start is part of the run.
    wr(0, 32'd4);
    wr(1, 32'd4);
    wr(2, 32'd4);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd2;
    bus.wr_data = 32'd2;
    run(3, cyc);
    chk("t8_count", 32'(bus.count), 32'd2);
`ifdef UNIQ_SORT_EN
    e0 = 32'd2; e1 = 32'd4;
`else
    e0 = 32'd4; e1 = 32'd2;
`endif
    rd_chk("t8_b0", 0, e0);
    rd_chk("t8_b1", 1, e1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
